// File: rtl/lc3_mem_interface.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : lc3_mem_interface
// Description : MAR/MDR memory-access stage of the LC-3 datapath. Captures
//               bus values into MAR/MDR, runs memory read/write transactions
//               with an ack handshake and a timeout, and decodes the
//               memory-mapped keyboard (KBSR/KBDR) and display (DSR/DDR)
//               registers. Raises o_R to the control FSM on completion.
// Ports       : i_Clk, i_Rst_n        clock / synchronous active-low reset
//               i_Bus, i_LD_MAR,
//               i_LD_MDR              bus capture into MAR / MDR
//               i_MIO_EN, i_R_W       access request and direction
//               o_MAR, o_MDR_OUT      register contents
//               o_R, o_Err            access complete / sticky timeout flag
//               o_Mem_*, i_Mem_*      external memory request/ack channel
//               i_Kb_*                keyboard character strobe
//               o_Disp_*, i_Disp_Ready display character handshake
// Revision    : 1.0 - initial release
// ============================================================================
module lc3_mem_interface #(
  parameter logic [15:0] KBSR_ADDR = 16'hFE00,
  parameter logic [15:0] KBDR_ADDR = 16'hFE02,
  parameter logic [15:0] DSR_ADDR  = 16'hFE04,
  parameter logic [15:0] DDR_ADDR  = 16'hFE06,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic [15:0] i_Bus,
  input  logic        i_LD_MAR,
  input  logic        i_LD_MDR,
  input  logic        i_MIO_EN,
  input  logic        i_R_W,
  output logic [15:0] o_MAR,
  output logic [15:0] o_MDR_OUT,
  output logic        o_R,
  output logic        o_Err,
  output logic        o_Mem_Req,
  output logic        o_Mem_We,
  output logic [15:0] o_Mem_Addr,
  output logic [15:0] o_Mem_Wdata,
  input  logic [15:0] i_Mem_Rdata,
  input  logic        i_Mem_Ack,
  input  logic        i_Kb_Valid,
  input  logic [7:0]  i_Kb_Data,
  output logic        o_Disp_Valid,
  output logic [7:0]  o_Disp_Data,
  input  logic        i_Disp_Ready
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DONE     = 2'd2
  } state_t;

  // Last counter value before the access is abandoned.
  localparam logic [15:0] c_TIMEOUT_LAST = 16'(TIMEOUT - 1);

  state_t      r_state;
  logic [15:0] r_mar;
  logic [15:0] r_mdr;
  logic        r_ready;
  logic        r_req;
  logic        r_we;
  logic        r_err;
  logic [15:0] r_cnt;
  logic        r_kb_flag;
  logic [7:0]  r_kbdr;
  logic        r_disp_valid;
  logic [7:0]  r_disp_data;

  logic w_is_kbsr;
  logic w_is_kbdr;
  logic w_is_dsr;
  logic w_is_ddr;
  logic w_is_dev;

  assign w_is_kbsr = (r_mar == KBSR_ADDR);
  assign w_is_kbdr = (r_mar == KBDR_ADDR);
  assign w_is_dsr  = (r_mar == DSR_ADDR);
  assign w_is_ddr  = (r_mar == DDR_ADDR);
  assign w_is_dev  = w_is_kbsr | w_is_kbdr | w_is_dsr | w_is_ddr;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      r_state      <= ST_IDLE;
      r_mar        <= 16'h0000;
      r_mdr        <= 16'h0000;
      r_ready      <= 1'b0;
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_err        <= 1'b0;
      r_cnt        <= 16'h0000;
      r_kb_flag    <= 1'b0;
      r_kbdr       <= 8'h00;
      r_disp_valid <= 1'b0;
      r_disp_data  <= 8'h00;
    end else begin
      // MDR bus load is only possible while no access is requested, so it
      // never collides with a memory or device read result.
      if (i_LD_MDR && !i_MIO_EN) begin
        r_mdr <= i_Bus;
      end

      // Display consumed its character; a DDR write below takes precedence.
      if (r_disp_valid && i_Disp_Ready) begin
        r_disp_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (i_LD_MAR) begin
            r_mar <= i_Bus;
          end
          if (i_MIO_EN) begin
            if (w_is_dev) begin
              // Device registers complete in the same edge.
              r_state <= ST_DONE;
              r_ready <= 1'b1;
              if (i_R_W) begin
                if (w_is_ddr) begin
                  r_disp_data  <= r_mdr[7:0];
                  r_disp_valid <= 1'b1;
                end
              end else begin
                if (w_is_kbsr) begin
                  r_mdr <= {r_kb_flag, 15'b0};
                end else if (w_is_kbdr) begin
                  r_mdr     <= {8'h00, r_kbdr};
                  r_kb_flag <= 1'b0;
                end else if (w_is_dsr) begin
                  r_mdr <= {~r_disp_valid, 15'b0};
                end else begin
                  r_mdr <= 16'h0000;
                end
              end
            end else begin
              r_state <= ST_MEM_WAIT;
              r_req   <= 1'b1;
              r_we    <= i_R_W;
              r_cnt   <= 16'h0000;
            end
          end
        end

        ST_MEM_WAIT: begin
          if (i_Mem_Ack) begin
            if (!r_we) begin
              r_mdr <= i_Mem_Rdata;
            end
            r_state <= ST_DONE;
            r_ready <= 1'b1;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
          end else if (r_cnt == c_TIMEOUT_LAST) begin
            // Abandon: reads return zero, writes are dropped.
            if (!r_we) begin
              r_mdr <= 16'h0000;
            end
            r_err   <= 1'b1;
            r_state <= ST_DONE;
            r_ready <= 1'b1;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        ST_DONE: begin
          if (i_LD_MAR) begin
            r_mar <= i_Bus;
          end
          if (!i_MIO_EN) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b0;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b0;
          r_req   <= 1'b0;
          r_we    <= 1'b0;
        end
      endcase

      // A new keystroke always lands, even when a KBDR read clears the flag
      // in the same edge (the read above already captured the old value).
      if (i_Kb_Valid) begin
        r_kbdr    <= i_Kb_Data;
        r_kb_flag <= 1'b1;
      end
    end
  end

  assign o_MAR        = r_mar;
  assign o_MDR_OUT    = r_mdr;
  assign o_R          = r_ready;
  assign o_Err        = r_err;
  assign o_Mem_Req    = r_req;
  assign o_Mem_We     = r_we;
  assign o_Mem_Addr   = r_mar;
  assign o_Mem_Wdata  = r_mdr;
  assign o_Disp_Valid = r_disp_valid;
  assign o_Disp_Data  = r_disp_data;

endmodule
`default_nettype wire

// File: doc/lc3_mem_interface.md
Name: lc3_mem_interface

Overview:
- MAR/MDR memory-access stage of the LC-3 datapath.
- Captures bus values into MAR and MDR, runs memory read/write transactions with an ack handshake, and decodes the LC-3 memory-mapped keyboard/display registers.
- Raises R to the control FSM when an access completes.
- o_MDR_OUT is the MDR source gated onto the bus by GateMDR; i_Bus is the driven bus value.

Parameters:
KBSR_ADDR, 16'hFE00, keyboard status register address
KBDR_ADDR, 16'hFE02, keyboard data register address
DSR_ADDR, 16'hFE04, display status register address
DDR_ADDR, 16'hFE06, display data register address
TIMEOUT, 255, max cycles in MEM_WAIT without ack before abort (1..65535)

Ports:
i_Clk  in  1  clock, all logic on posedge
i_Rst_n  in  1  synchronous active-low reset
i_Bus  in  16  current bus value
i_LD_MAR  in  1  load MAR from bus
i_LD_MDR  in  1  load MDR from bus (only when i_MIO_EN=0)
i_MIO_EN  in  1  memory/IO access request, held by control until o_R
i_R_W  in  1  1=write, 0=read; sampled with access start
o_MAR  out  16  MAR contents
o_MDR_OUT  out  16  MDR contents (to bus driver)
o_R  out  1  access complete (ready)
o_Err  out  1  sticky timeout flag
o_Mem_Req  out  1  memory request, high throughout MEM_WAIT
o_Mem_We  out  1  write enable, valid with o_Mem_Req
o_Mem_Addr  out  16  equals MAR
o_Mem_Wdata  out  16  equals MDR
i_Mem_Rdata  in  16  read data, valid with i_Mem_Ack
i_Mem_Ack  in  1  completes the memory transaction
i_Kb_Valid  in  1  one-cycle keyboard character strobe
i_Kb_Data  in  8  keyboard character
o_Disp_Valid  out  1  display character pending
o_Disp_Data  out  8  display character
i_Disp_Ready  in  1  display accepts when o_Disp_Valid & i_Disp_Ready

Behaviour:
- Reset (i_Rst_n=0 at posedge, any state): MAR=MDR=0, state IDLE, o_R=0, o_Err=0, o_Mem_Req=0, o_Mem_We=0, KBSR flag=0, KBDR=0, o_Disp_Valid=0, o_Disp_Data=0. Mid-transaction reset abandons the access; no MDR update.
- Register loads:
  - LD_MAR: MAR<=i_Bus next edge in IDLE or DONE; ignored in MEM_WAIT.
  - LD_MDR with MIO_EN=0: MDR<=i_Bus.
- FSM states: IDLE, MEM_WAIT, DONE.
  - IDLE & i_MIO_EN:
    - MAR is one of the four device addresses -> device op this edge -> DONE.
    - Otherwise -> MEM_WAIT, latching i_R_W into o_Mem_We, timeout counter=0.
  - MEM_WAIT:
    - o_Mem_Req=1.
    - On i_Mem_Ack: read loads MDR<=i_Mem_Rdata; -> DONE.
    - Ack in the first MEM_WAIT cycle is legal (min latency: start edge + 1 cycle).
    - Counter increments per cycle without ack; at count==TIMEOUT-1 with no ack -> DONE, o_Err<=1; a read loads MDR<=0; a write is dropped.
  - DONE: o_R=1 (Moore, registered state). Stay while i_MIO_EN=1; -> IDLE when i_MIO_EN=0. No new access until IDLE is re-entered.
- o_Err clears only on reset.
- Device reads load MDR:
  - KBSR -> {flag,15'b0}.
  - KBDR -> {8'b0,KBDR}; clears flag.
  - DSR -> {~o_Disp_Valid,15'b0}.
  - DDR -> 0.
- Device writes:
  - DDR -> o_Disp_Data<=MDR[7:0], o_Disp_Valid<=1. A write while valid overwrites data; valid stays 1.
  - Writes to KBSR, KBDR and DSR are ignored.
- Keyboard: i_Kb_Valid -> KBDR<=i_Kb_Data, flag<=1. If i_Kb_Valid coincides with a KBDR read, the read returns the old KBDR, the new char is stored and the flag stays 1.
- Display: valid&ready -> o_Disp_Valid<=0. If this coincides with a DDR write, the write wins (valid stays 1 with new data).
- Device ops never touch o_Mem_Req.
- Memory address is 16-bit, no wrap logic; o_Mem_Addr/o_Mem_Wdata are continuous copies of MAR/MDR.

Test Plan:
- Reset: drive i_Rst_n=0 with all inputs high for 2 cycles -> MAR=MDR=0, o_R=0, o_Err=0, o_Mem_Req=0, o_Disp_Valid=0.
- Read: Bus=16'h3000 with LD_MAR; then MIO_EN=1, R_W=0; ack on the 3rd MEM_WAIT cycle with Rdata=16'hBEEF -> o_Mem_Req high 3 cycles, o_Mem_Addr=16'h3000, MDR=16'hBEEF, o_R=1 next cycle; drop MIO_EN -> IDLE.
- Write: MAR=16'h4000, MDR=16'h1234 via LD_MDR; MIO_EN=1, R_W=1; ack after 1 cycle -> o_Mem_We=1, Wdata=16'h1234, MDR unchanged, o_R asserted.
- Keyboard: Kb_Valid with 8'h41; read KBSR -> MDR=16'h8000; read KBDR -> MDR=16'h0041; read KBSR -> MDR=16'h0000; no o_Mem_Req throughout.
- Display: MDR=16'h0058, write DDR -> o_Disp_Valid=1, o_Disp_Data=8'h58; DSR read -> 16'h0000; assert i_Disp_Ready 1 cycle -> valid=0; DSR read -> 16'h8000.
- Timeout with TIMEOUT=4: read to 16'h3000 with no ack -> exactly 4 cycles of o_Mem_Req, MDR=0, o_Err=1, o_R=1. Also apply reset mid-MEM_WAIT -> IDLE with MDR unchanged from its reset value of 0.
